uart_rx_core: RTL

Serial receive engine of the UART block; sits directly upstream of the APB slave register interface. Converts the asynchronous `serial_in` line into framed data words using the bit period and data size programmed through the APB slave. Reports `rx_data`, `data_ready`, `overrun_error` and `framing_error` to the slave, and clears `data_ready` and `overrun_error` when the slave pulses `data_read`.

---
 rtl/uart_rx_core_if.sv | 23 ++
 rtl/uart_rx_core.sv | 138 +++++++++++++
 2 files changed

// File: rtl/uart_rx_core_if.sv
// Signal bundle between the UART receive core and the APB slave register block.
interface uart_rx_core_if;
  logic        serial_in;
  logic [13:0] bit_period;
  logic [3:0]  data_size;
  logic        data_read;
  logic [7:0]  rx_data;
  logic        data_ready;
  logic        overrun_error;
  logic        framing_error;

  // Register-block side: drives line and configuration, consumes status.
  modport master (
    output serial_in, bit_period, data_size, data_read,
    input  rx_data, data_ready, overrun_error, framing_error
  );

  // Receive-core side.
  modport slave (
    input  serial_in, bit_period, data_size, data_read,
    output rx_data, data_ready, overrun_error, framing_error
  );
endinterface

// File: rtl/uart_rx_core.sv
// UART serial receive engine: synchronizes serial_in, frames start/data/stop
// bits using a bit period and data size frozen at start-bit detection, and
// reports the received word with ready/overrun/framing status.
// SYNC_STAGES must be 2 or 3.
module uart_rx_core #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic          clk,
  input  logic          rst,
  uart_rx_core_if.slave bus
);

  localparam int unsigned CNT_W  = 14;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned NB_W   = 4;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e                 state_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_dly_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [CNT_W-1:0]       bp_q;
  logic [NB_W-1:0]        n_q;
  logic [NB_W-1:0]        bit_cnt_q;
  logic [DATA_W-1:0]      shift_q;
  logic [DATA_W-1:0]      rx_data_q;
  logic                   data_ready_q;
  logic                   overrun_q;
  logic                   framing_q;

  logic                   s_c;
  logic                   s_fall_c;
  logic [CNT_W-1:0]       half_c;
  logic [CNT_W-1:0]       bp_d;
  logic [NB_W-1:0]        n_d;
  logic [DATA_W-1:0]      shift_d;

  // Synchronized line, falling-edge detect and frame parameters to latch.
  always_comb begin
    s_c      = sync_q[SYNC_STAGES-1];
    s_fall_c = s_dly_q & ~s_c;
    half_c   = bp_q >> 1;
    bp_d     = (bus.bit_period < CNT_W'(4)) ? CNT_W'(4) : bus.bit_period;
    n_d      = (bus.data_size >= NB_W'(5) && bus.data_size <= NB_W'(8))
               ? bus.data_size : NB_W'(8);
    shift_d  = (shift_q >> 1) | (DATA_W'(s_c) << (n_q - NB_W'(1)));
  end

  // Synchronizer, frame FSM and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      sync_q       <= '1;
      s_dly_q      <= 1'b1;
      cnt_q        <= '0;
      bp_q         <= CNT_W'(4);
      n_q          <= NB_W'(8);
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      rx_data_q    <= '0;
      data_ready_q <= 1'b0;
      overrun_q    <= 1'b0;
      framing_q    <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], bus.serial_in};
      s_dly_q <= s_c;

      // A read clears the flags; a coincident good completion below overrides.
      if (bus.data_read) begin
        data_ready_q <= 1'b0;
        overrun_q    <= 1'b0;
      end

      // Counter is preloaded with 1 so it equals the elapsed cycles in a bit.
      case (state_q)
        IDLE: begin
          if (s_fall_c) begin
            bp_q    <= bp_d;
            n_q     <= n_d;
            cnt_q   <= CNT_W'(1);
            state_q <= START;
          end
        end
        START: begin
          if (cnt_q == half_c) begin
            if (s_c) begin
              state_q <= IDLE;
            end else begin
              shift_q   <= '0;
              framing_q <= 1'b0;
              cnt_q     <= CNT_W'(1);
              bit_cnt_q <= '0;
              state_q   <= DATA;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        DATA: begin
          if (cnt_q == bp_q) begin
            shift_q   <= shift_d;
            cnt_q     <= CNT_W'(1);
            bit_cnt_q <= bit_cnt_q + NB_W'(1);
            if (bit_cnt_q == n_q - NB_W'(1)) begin
              state_q <= STOP;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        STOP: begin
          if (cnt_q == bp_q) begin
            state_q <= IDLE;
            if (s_c) begin
              rx_data_q    <= shift_q;
              data_ready_q <= 1'b1;
              if (data_ready_q && !bus.data_read) begin
                overrun_q <= 1'b1;
              end
            end else begin
              framing_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.rx_data       = rx_data_q;
  assign bus.data_ready    = data_ready_q;
  assign bus.overrun_error = overrun_q;
  assign bus.framing_error = framing_q;

endmodule
